// File: rtl/nkb_counter_4b.sv
// 4-bit natural-binary up/down counter with clock-enable prescaler,
// synchronous load and registered step / terminal-count pulses.
module nkb_counter_4b #(
   parameter int unsigned PRESCALE = 1,
   parameter int unsigned PW       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] q,
   output logic       step,
   output logic       tc
);

   localparam int unsigned QW = 4;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_cnt;
   logic          pre_done;
   logic          wrap;

   assign pre_done = (pre_cnt == PRE_LAST);
   assign wrap     = up ? (q == {QW{1'b1}}) : (q == {QW{1'b0}});

   // Priority: reset, load, enabled count, hold
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q       <= '0;
         pre_cnt <= '0;
         step    <= 1'b0;
         tc      <= 1'b0;
      end else if (load) begin
         q       <= load_val;
         pre_cnt <= '0;
         step    <= 1'b0;
         tc      <= 1'b0;
      end else if (en) begin
         if (pre_done) begin
            pre_cnt <= '0;
            step    <= 1'b1;
            tc      <= wrap;
            q       <= up ? q + QW'(1) : q - QW'(1);
         end else begin
            pre_cnt <= pre_cnt + PW'(1);
            step    <= 1'b0;
            tc      <= 1'b0;
         end
      end else begin
         step <= 1'b0;
         tc   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nkb_counter_4b.sv
// Directed bench for nkb_counter_4b: one instance with PRESCALE=1 and one
// with PRESCALE=3 share stimulus; each phase starts from reset or load.
module tb_nkb_counter_4b;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] q1, q3;
   logic       step1, step3, tc1, tc3;

   int tests;
   int fails;

   nkb_counter_4b #(.PRESCALE(1), .PW(16)) u_p1 (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
      .load_val(load_val), .q(q1), .step(step1), .tc(tc1)
   );

   nkb_counter_4b #(.PRESCALE(3), .PW(16)) u_p3 (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
      .load_val(load_val), .q(q3), .step(step3), .tc(tc3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // q, step, tc of the PRESCALE=1 instance
   task automatic chk1(input string tag, input logic [3:0] eq, input logic es, input logic et);
      chk({tag, ".q"}, q1, eq);
      chk({tag, ".step"}, 4'(step1), 4'(es));
      chk({tag, ".tc"}, 4'(tc1), 4'(et));
   endtask

   // q, step, tc of the PRESCALE=3 instance
   task automatic chk3(input string tag, input logic [3:0] eq, input logic es, input logic et);
      chk({tag, ".q"}, q3, eq);
      chk({tag, ".step"}, 4'(step3), 4'(es));
      chk({tag, ".tc"}, 4'(tc3), 4'(et));
   endtask

   function automatic logic [3:0] gray(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   initial begin
      logic [3:0] prev_g;
      logic [3:0] exp_q;
      logic [3:0] diff;
      tests = 0;
      fails = 0;
      rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd7;

      // Reset overrides load and en
      tick(); tick();
      chk1("rst_p1", 4'd0, 1'b0, 1'b0);
      chk3("rst_p3", 4'd0, 1'b0, 1'b0);

      rst_n = 1'b1; load = 1'b0;
      tick(); chk1("cnt1", 4'd1, 1'b1, 1'b0);
      tick(); chk1("cnt2", 4'd2, 1'b1, 1'b0);
      tick(); chk1("cnt3", 4'd3, 1'b1, 1'b0);

      en = 1'b0;
      tick(); chk1("hold", 4'd3, 1'b0, 1'b0);
      en = 1'b1;

      // Up wrap
      load = 1'b1; load_val = 4'd14;
      tick(); chk1("ld14", 4'd14, 1'b0, 1'b0);
      load = 1'b0;
      tick(); chk1("up15", 4'd15, 1'b1, 1'b0);
      tick(); chk1("upwrap", 4'd0, 1'b1, 1'b1);
      tick(); chk1("up1", 4'd1, 1'b1, 1'b0);

      // Load wins over a wrapping step: no step, no tc
      load = 1'b1; load_val = 4'd15;
      tick(); chk1("ld15", 4'd15, 1'b0, 1'b0);
      load_val = 4'd5;
      tick(); chk1("ldwin", 4'd5, 1'b0, 1'b0);

      // Down wrap and direction change
      load_val = 4'd1; up = 1'b0;
      tick(); chk1("ld1", 4'd1, 1'b0, 1'b0);
      load = 1'b0;
      tick(); chk1("dn0", 4'd0, 1'b1, 1'b0);
      tick(); chk1("dnwrap", 4'd15, 1'b1, 1'b1);
      up = 1'b1;
      tick(); chk1("dirwrap", 4'd0, 1'b1, 1'b1);
      tick(); chk1("dir1", 4'd1, 1'b1, 1'b0);

      // Gray integration: up 0..15..0 then down back to 0
      load = 1'b1; load_val = 4'd0;
      tick(); chk1("gld0", 4'd0, 1'b0, 1'b0);
      load = 1'b0;
      exp_q  = 4'd0;
      prev_g = gray(q1);
      for (int i = 0; i < 32; i++) begin
         up = (i < 16);
         exp_q = up ? exp_q + 4'd1 : exp_q - 4'd1;
         tick();
         chk("gray.q", q1, exp_q);
         diff = gray(q1) ^ prev_g;
         chk("gray.onebit", 4'($countones(diff)), 4'd1);
         prev_g = gray(q1);
      end

      // Prescaler = 3
      rst_n = 1'b0; up = 1'b1; en = 1'b1;
      tick(); chk3("p3rst", 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick(); chk3("p3e1", 4'd0, 1'b0, 1'b0);
      tick(); chk3("p3e2", 4'd0, 1'b0, 1'b0);
      tick(); chk3("p3e3", 4'd1, 1'b1, 1'b0);
      tick(); chk3("p3e4", 4'd1, 1'b0, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(); chk3("p3hold", 4'd1, 1'b0, 1'b0);
      end
      en = 1'b1;
      tick(); chk3("p3res1", 4'd1, 1'b0, 1'b0);
      tick(); chk3("p3res2", 4'd2, 1'b1, 1'b0);
      tick(); chk3("p3e7", 4'd2, 1'b0, 1'b0);
      tick(); chk3("p3e8", 4'd2, 1'b0, 1'b0);
      tick(); chk3("p3e9", 4'd3, 1'b1, 1'b0);

      // Load at pre_cnt = 2 beats the pending step
      tick(); tick();
      chk3("p3pre2", 4'd3, 1'b0, 1'b0);
      load = 1'b1; load_val = 4'd9;
      tick(); chk3("p3ld9", 4'd9, 1'b0, 1'b0);
      load = 1'b0;
      tick(); chk3("p3ld+1", 4'd9, 1'b0, 1'b0);
      tick(); chk3("p3ld+2", 4'd9, 1'b0, 1'b0);
      tick(); chk3("p3ld+3", 4'd10, 1'b1, 1'b0);

      // Reset mid-prescale discards progress
      tick(); tick();
      rst_n = 1'b0;
      tick(); chk3("p3midrst", 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick(); tick();
      chk3("p3rst+2", 4'd0, 1'b0, 1'b0);
      tick(); chk3("p3rst+3", 4'd1, 1'b1, 1'b0);

      // Down wrap through the prescaler
      up = 1'b0;
      tick(); tick(); tick();
      chk3("p3dn0", 4'd0, 1'b1, 1'b0);
      tick(); tick(); tick();
      chk3("p3dnwrap", 4'd15, 1'b1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nkb_counter_4b.md
Name: nkb_counter_4b

Overview:
- 4-bit natural-binary (NKB) up/down counter with a built-in clock-enable prescaler, synchronous load and terminal-count flag.
- Sits directly upstream of the binary-to-Gray converter: its q output drives the converter's 4-bit binary input, producing a Gray-code counter for display and test.
- Single clock domain; all outputs are registered.

Parameters:
- PRESCALE, 1, number of enabled clock cycles per count step; legal range 1..65535; 1 = step on every enabled cycle.
- PW, 16, width of the internal prescaler register; must satisfy 2^PW >= PRESCALE.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- en  input  1  count enable; when low the counter and prescaler hold.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled on the step cycle.
- load  input  1  synchronous load strobe.
- load_val  input  4  value loaded into q when load = 1.
- q  output  4  registered binary count; connects to the Gray converter input.
- step  output  1  registered one-cycle pulse; high in the cycle after each count change caused by the prescaler (not by load).
- tc  output  1  registered one-cycle pulse; high in the cycle after a wrap (up: 15->0; down: 0->15).

Behaviour:
- Internal state: q[3:0] and pre_cnt[PW-1:0].
- Priority at each rising edge of clk, highest first: reset, load, en, hold.
- Reset (rst_n = 0):
  - q = 0, pre_cnt = 0, step = 0, tc = 0.
  - Overrides load and en.
  - Reset mid-count discards prescaler progress.
- Load (rst_n = 1, load = 1):
  - q <= load_val, pre_cnt <= 0, step <= 0, tc <= 0.
  - Independent of en.
  - A full PRESCALE enabled cycles must elapse after load before the next step.
- Count (rst_n = 1, load = 0, en = 1):
  - If pre_cnt == PRESCALE-1:
    - pre_cnt <= 0, step <= 1.
    - q <= q+1 mod 16 if up = 1; q <= q-1 mod 16 if up = 0.
    - tc <= 1 exactly when (up = 1 and q == 15) or (up = 0 and q == 0); else tc <= 0.
  - Else: pre_cnt <= pre_cnt+1, q holds, step <= 0, tc <= 0.
- Hold (rst_n = 1, load = 0, en = 0):
  - q and pre_cnt hold, step <= 0, tc <= 0.
  - Dropping en mid-prescale freezes progress; re-asserting en resumes from the frozen pre_cnt.
- Latency:
  - With PRESCALE = P and en held high from pre_cnt = 0, q changes on the P-th rising edge.
  - step and tc assert on that same edge (visible one cycle after the triggering state).
- Direction change: up may toggle at any time; only its value on the step edge matters. There is no glitch or skipped value.
- Simultaneous load and step condition: load wins. No step or tc pulse is produced.
- Overflow: q arithmetic is strictly modulo 16 and never saturates.
- Downstream contract: q changes by at most one LSB per step (except on load), so the Gray output changes by exactly one bit per step.
- No combinational path from any input to any output.

Test Plan:
- Reset, PRESCALE = 1: hold rst_n = 0 for 2 cycles with en = 1, load = 1 -> q = 0, step = 0, tc = 0 afterwards. Release rst_n with load = 0, en = 1, up = 1 -> q = 1, 2, 3 on successive edges; step high every cycle.
- Wrap up, PRESCALE = 1: load 4'd14, then en = 1, up = 1 -> q = 15, then 0 with tc = 1 for exactly the cycle q = 0; then q = 1 with tc = 0.
- Wrap down and direction change, PRESCALE = 1: load 4'd1, up = 0 -> q = 0, then 15 with tc = 1. Set up = 1 -> q = 0 with tc = 1 (up wrap). Next edge q = 1, tc = 0.
- Prescaler, PRESCALE = 3: from reset with en = 1, up = 1 -> q increments on edges 3, 6, 9; step pulses only on those edges. Drop en after edge 4 for 5 cycles -> q = 1 holds, no step. Re-enable -> q = 2 two edges later.
- Load priority, PRESCALE = 3: with pre_cnt = 2 and en = 1, assert load with load_val = 4'd9 -> q = 9, step = 0, tc = 0. Next step occurs 3 enabled edges later -> q = 10.
- Gray integration: chain with the converter, PRESCALE = 1, count 0..15..0 -> consecutive Gray outputs differ by exactly one bit, including the 15->0 transition (1000 -> 0000).
